// File: rtl/vscale_htif_tohost_monitor_pkg.sv
// vscale_htif_pkg: shared types and constants for the HTIF tohost monitor
package vscale_htif_pkg;
  localparam int HTIF_PCR_ADDR_WIDTH = 12;
  localparam int HTIF_PCR_DATA_WIDTH = 64;
  // tohost CSR address, mirrored from vscale_csr_addr_map.vh
  localparam logic [HTIF_PCR_ADDR_WIDTH-1:0] CSR_ADDR_TO_HOST = 12'h780;
  localparam logic [HTIF_PCR_DATA_WIDTH-1:0] TOHOST_PASS = 64'h1;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RD_REQ,
    ST_RD_RESP,
    ST_CLR_REQ,
    ST_CLR_RESP,
    ST_DONE
  } htif_mon_state_e;
endpackage

// File: rtl/vscale_htif_tohost_monitor_if.sv
// vscale_htif_tohost_monitor_if: HTIF PCR request/response channel between host agent and core
interface vscale_htif_tohost_monitor_if;
  import vscale_htif_pkg::*;
  logic                           htif_pcr_req_valid;
  logic                           htif_pcr_req_ready;
  logic                           htif_pcr_req_rw;
  logic [HTIF_PCR_ADDR_WIDTH-1:0] htif_pcr_req_addr;
  logic [HTIF_PCR_DATA_WIDTH-1:0] htif_pcr_req_data;
  logic                           htif_pcr_resp_valid;
  logic                           htif_pcr_resp_ready;
  logic [HTIF_PCR_DATA_WIDTH-1:0] htif_pcr_resp_data;
  modport master (
    output htif_pcr_req_valid, htif_pcr_req_rw, htif_pcr_req_addr, htif_pcr_req_data,
    output htif_pcr_resp_ready,
    input  htif_pcr_req_ready, htif_pcr_resp_valid, htif_pcr_resp_data
  );
  modport slave (
    input  htif_pcr_req_valid, htif_pcr_req_rw, htif_pcr_req_addr, htif_pcr_req_data,
    input  htif_pcr_resp_ready,
    output htif_pcr_req_ready, htif_pcr_resp_valid, htif_pcr_resp_data
  );
endinterface

// File: rtl/vscale_htif_tohost_monitor.sv
// vscale_htif_tohost_monitor: polls tohost over the HTIF PCR port and reports pass/fail/timeout
module vscale_htif_tohost_monitor
  import vscale_htif_pkg::*;
#(
  parameter int unsigned POLL_INTERVAL  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         enable,
  vscale_htif_tohost_monitor_if.master htif,
  output logic                         done,
  output logic                         pass,
  output logic [62:0]                  fail_code,
  output logic                         timeout,
  output logic [15:0]                  poll_count
);
  localparam int IW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] IVL_LOAD = IW'(POLL_INTERVAL - 1);
  localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_CYCLES);

  htif_mon_state_e                state_q, state_d;
  logic [IW-1:0]                  ivl_q, ivl_d;
  logic [TW-1:0]                  tcnt_q, tcnt_d;
  logic [HTIF_PCR_DATA_WIDTH-1:0] cap_q, cap_d;
  logic [15:0]                    pcnt_q, pcnt_d;
  logic                           done_q, done_d;
  logic                           pass_q, pass_d;
  logic [62:0]                    fc_q, fc_d;
  logic                           to_q, to_d;
  logic                           ticking, to_hit;

  always_comb begin
    state_d = state_q;
    ivl_d   = ivl_q;
    tcnt_d  = tcnt_q;
    cap_d   = cap_q;
    pcnt_d  = pcnt_q;
    done_d  = done_q;
    pass_d  = pass_q;
    fc_d    = fc_q;
    to_d    = to_q;
    ticking = (state_q != ST_IDLE) && (state_q != ST_DONE);
    to_hit  = ticking && (tcnt_q + TW'(1) == TO_LIMIT);
    if (ticking) tcnt_d = tcnt_q + TW'(1);
    unique case (state_q)
      ST_IDLE: if (enable) begin
        state_d = ST_WAIT;
        ivl_d   = IVL_LOAD;
        tcnt_d  = '0;
      end
      ST_WAIT: begin
        if (!enable) state_d = ST_IDLE;
        else if (ivl_q == '0) state_d = ST_RD_REQ;
        else ivl_d = ivl_q - IW'(1);
      end
      ST_RD_REQ: if (htif.htif_pcr_req_ready) state_d = ST_RD_RESP;
      ST_RD_RESP: if (htif.htif_pcr_resp_valid) begin
        if (htif.htif_pcr_resp_data == '0) begin
          pcnt_d  = &pcnt_q ? pcnt_q : pcnt_q + 16'd1;
          ivl_d   = IVL_LOAD;
          state_d = enable ? ST_WAIT : ST_IDLE;
        end else begin
          cap_d   = htif.htif_pcr_resp_data;
          state_d = ST_CLR_REQ;
        end
      end
      ST_CLR_REQ: if (htif.htif_pcr_req_ready) state_d = ST_CLR_RESP;
      ST_CLR_RESP: if (htif.htif_pcr_resp_valid) begin
        state_d = ST_DONE;
        done_d  = 1'b1;
        pass_d  = cap_q == TOHOST_PASS;
        fc_d    = cap_q[63:1];
      end
      default: ;
    endcase
    // timeout overrides whatever the channel did this cycle
    if (to_hit) begin
      state_d = ST_DONE;
      cap_d   = cap_q;
      pcnt_d  = pcnt_q;
      done_d  = 1'b1;
      to_d    = 1'b1;
      pass_d  = 1'b0;
      fc_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ivl_q   <= '0;
      tcnt_q  <= '0;
      cap_q   <= '0;
      pcnt_q  <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fc_q    <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ivl_q   <= ivl_d;
      tcnt_q  <= tcnt_d;
      cap_q   <= cap_d;
      pcnt_q  <= pcnt_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fc_q    <= fc_d;
      to_q    <= to_d;
    end
  end

  assign htif.htif_pcr_req_valid  = (state_q == ST_RD_REQ) || (state_q == ST_CLR_REQ);
  assign htif.htif_pcr_req_rw     = state_q == ST_CLR_REQ;
  assign htif.htif_pcr_req_addr   = CSR_ADDR_TO_HOST;
  assign htif.htif_pcr_req_data   = '0;
  assign htif.htif_pcr_resp_ready = (state_q == ST_RD_RESP) || (state_q == ST_CLR_RESP);
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail_code  = fc_q;
  assign timeout    = to_q;
  assign poll_count = pcnt_q;
endmodule

// File: tb/tb_vscale_htif_tohost_monitor.sv
// tb_vscale_htif_tohost_monitor: scoreboard bench with a randomized HTIF responder
module tb_vscale_htif_tohost_monitor;
  localparam int P = 4;
  localparam int T = 50;
  typedef struct packed { logic rw; logic [11:0] addr; logic [63:0] data; } req_t;
  typedef struct packed { logic pass; logic [62:0] fc; logic to; logic [15:0] pc; } res_t;
  localparam req_t RD = '{rw: 1'b0, addr: 12'h780, data: 64'h0};
  localparam req_t WR = '{rw: 1'b1, addr: 12'h780, data: 64'h0};

  logic clk = 1'b0, reset_n = 1'b0, enable = 1'b0;
  logic done, pass, timeout;
  logic [62:0] fail_code;
  logic [15:0] poll_count;
  vscale_htif_tohost_monitor_if bus();
  vscale_htif_tohost_monitor #(.POLL_INTERVAL(P), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .htif(bus),
    .done(done), .pass(pass), .fail_code(fail_code), .timeout(timeout), .poll_count(poll_count)
  );
  always #5 clk = ~clk;

  int total = 0, bad = 0;
  req_t exp_q[$];
  res_t res_q[$];
  logic [63:0] rd_vals[$];
  bit rand_lat = 0, block_wr = 0;
  int stall = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // responder: random ready stalls and response latency, read data from rd_vals
  bit pend = 0, hs_req = 0, hs_rsp = 0, hs_rw = 0;
  int rdly = 0;
  logic [63:0] pdata = '0;
  always @(negedge clk) begin
    if (!reset_n) begin
      pend = 0; hs_req = 0; hs_rsp = 0;
      bus.htif_pcr_req_ready = 1'b0;
      bus.htif_pcr_resp_valid = 1'b0;
      bus.htif_pcr_resp_data = '0;
    end else begin
      if (hs_rsp) pend = 0;
      if (hs_req) begin
        pend = 1;
        rdly = rand_lat ? int'($urandom_range(0, 2)) : 0;
        pdata = hs_rw ? {$urandom, $urandom} : (rd_vals.size() > 0 ? rd_vals.pop_front() : 64'h0);
        stall = rand_lat ? int'($urandom_range(0, 2)) : 0;
      end
      bus.htif_pcr_req_ready = !(block_wr && bus.htif_pcr_req_rw) &&
                               !(bus.htif_pcr_req_valid && stall > 0);
      if (bus.htif_pcr_req_valid && stall > 0) stall--;
      bus.htif_pcr_resp_valid = pend && rdly == 0;
      bus.htif_pcr_resp_data = pend ? pdata : 64'h0;
      if (pend && rdly > 0) rdly--;
      hs_req = bus.htif_pcr_req_valid && bus.htif_pcr_req_ready;
      hs_rw = bus.htif_pcr_req_rw;
      hs_rsp = bus.htif_pcr_resp_valid && bus.htif_pcr_resp_ready;
    end
  end

  // monitor: pops expected requests on each transfer and the expected result when done rises
  req_t cur, last_req;
  bit last_wait = 0, last_hs = 0, done_seen = 0;
  always @(negedge clk) begin
    #1;
    if (!reset_n) begin
      last_wait = 0; last_hs = 0; done_seen = 0;
    end else begin
      cur = '{rw: bus.htif_pcr_req_rw, addr: bus.htif_pcr_req_addr, data: bus.htif_pcr_req_data};
      if (last_wait && !timeout) begin
        chk("req_hold_valid", 128'(bus.htif_pcr_req_valid), 128'(1));
        chk("req_hold_fields", 128'(cur), 128'(last_req));
      end
      if (last_hs && !timeout) chk("resp_ready_after_req", 128'(bus.htif_pcr_resp_ready), 128'(1));
      if (bus.htif_pcr_req_valid && bus.htif_pcr_req_ready) begin
        chk("req_expected", 128'(exp_q.size() > 0), 128'(1));
        if (exp_q.size() > 0) chk("req_fields", 128'(cur), 128'(exp_q.pop_front()));
      end
      if (done && !done_seen) begin
        done_seen = 1;
        chk("done_expected", 128'(res_q.size() > 0), 128'(1));
        if (res_q.size() > 0)
          chk("result", 128'({pass, fail_code, timeout, poll_count}), 128'(res_q.pop_front()));
      end
      last_wait = bus.htif_pcr_req_valid && !bus.htif_pcr_req_ready;
      last_hs = bus.htif_pcr_req_valid && bus.htif_pcr_req_ready;
      last_req = cur;
    end
  end

  task automatic start_reset();
    reset_n = 0; enable = 0; rand_lat = 0; block_wr = 0; stall = 0;
    rd_vals.delete(); exp_q.delete(); res_q.delete();
  endtask
  task automatic release_reset();
    repeat (2) @(negedge clk);
    #3 reset_n = 1;
  endtask
  task automatic go();
    @(negedge clk);
    #3 enable = 1;
  endtask
  task automatic plan(input int n, input logic [63:0] v);
    for (int i = 0; i < n; i++) begin
      rd_vals.push_back(64'h0);
      exp_q.push_back(RD);
    end
    rd_vals.push_back(v);
    exp_q.push_back(RD);
    exp_q.push_back(WR);
    res_q.push_back('{pass: (v == 64'h1), fc: v[63:1], to: 1'b0, pc: 16'(n)});
  endtask
  task automatic wait_done(input int lim);
    int c = 0;
    while (!done && c < lim) begin
      @(negedge clk);
      c++;
    end
    chk("done_within_budget", 128'(done), 128'(1));
  endtask
  task automatic drain();
    @(negedge clk);
    #3 chk("scoreboard_drained", 128'(exp_q.size() + res_q.size()), 128'(0));
  endtask
  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_valid"}, 128'(bus.htif_pcr_req_valid), 128'(0));
    chk({tag, "_req_rw"}, 128'(bus.htif_pcr_req_rw), 128'(0));
    chk({tag, "_req_addr"}, 128'(bus.htif_pcr_req_addr), 128'(12'h780));
    chk({tag, "_req_data"}, 128'(bus.htif_pcr_req_data), 128'(0));
    chk({tag, "_resp_ready"}, 128'(bus.htif_pcr_resp_ready), 128'(0));
    chk({tag, "_status"}, 128'({done, pass, timeout, fail_code, poll_count}), 128'(0));
  endtask

  logic [63:0] v;
  int c;
  bit seen;
  initial begin
    start_reset();
    repeat (2) @(negedge clk);
    #2 check_reset_outputs("reset");
    release_reset();

    plan(2, 64'h1);
    go();
    repeat (P) @(posedge clk);
    @(negedge clk) chk("req_latency_low", 128'(bus.htif_pcr_req_valid), 128'(0));
    @(posedge clk);
    @(negedge clk) chk("req_latency_high", 128'(bus.htif_pcr_req_valid), 128'(1));
    wait_done(100);
    drain();
    enable = 0;
    repeat (5) @(negedge clk);
    chk("done_sticky", 128'({done, pass, bus.htif_pcr_req_valid}), 128'(3'b110));

    start_reset(); release_reset();
    plan(0, 64'h7);
    go();
    wait_done(100);
    drain();
    chk("fail_code_7", 128'({pass, fail_code}), 128'({1'b0, 63'd3}));

    start_reset(); release_reset();
    stall = 5;
    plan(0, 64'h1);
    go();
    wait_done(100);
    drain();

    start_reset(); release_reset();
    for (int i = 0; i < (T - 1) / (P + 2); i++) exp_q.push_back(RD);
    res_q.push_back('{pass: 1'b0, fc: 63'h0, to: 1'b1, pc: 16'((T - 1) / (P + 2))});
    go();
    @(posedge clk);
    repeat (T - 1) @(posedge clk);
    @(negedge clk) chk("timeout_before_limit", 128'({timeout, done}), 128'(0));
    @(posedge clk);
    @(negedge clk) chk("timeout_at_limit", 128'({timeout, done, pass}), 128'(3'b110));
    drain();

    start_reset(); release_reset();
    exp_q.push_back(RD);
    stall = 3;
    go();
    c = 0;
    while (!bus.htif_pcr_req_valid && c < 20) begin @(negedge clk); c++; end
    chk("rd_req_seen", 128'(bus.htif_pcr_req_valid), 128'(1));
    #3 enable = 0;
    c = 0;
    while (poll_count != 16'd1 && c < 30) begin @(negedge clk); c++; end
    chk("drop_read_completed", 128'(poll_count), 128'(1));
    seen = 0;
    repeat (20) begin @(negedge clk); #2 seen |= bus.htif_pcr_req_valid; end
    chk("no_req_after_drop", 128'({seen, done}), 128'(0));
    drain();

    start_reset(); release_reset();
    rd_vals.push_back(64'h5);
    exp_q.push_back(RD);
    block_wr = 1;
    go();
    c = 0;
    while (!(bus.htif_pcr_req_valid && bus.htif_pcr_req_rw) && c < 60) begin @(negedge clk); c++; end
    chk("clr_req_seen", 128'(bus.htif_pcr_req_valid && bus.htif_pcr_req_rw), 128'(1));
    #2 reset_n = 0;
    #1 check_reset_outputs("async_reset");
    chk("mid_clr_drained", 128'(exp_q.size()), 128'(0));
    start_reset(); release_reset();
    plan(1, 64'h1);
    go();
    wait_done(100);
    drain();

    for (int it = 0; it < 8; it++) begin
      start_reset(); release_reset();
      rand_lat = 1;
      v = {$urandom, $urandom};
      case ($urandom_range(0, 2))
        0: v = 64'h1;
        1: v = 64'($urandom_range(2, 15));
        default: ;
      endcase
      if (v == 64'h0) v = 64'h2;
      plan(int'($urandom_range(0, 2)), v);
      go();
      wait_done(100);
      drain();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
